// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width for a frame of the given size (at least one bit).
    function automatic int cnt_w(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal count.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign cnt = cnt_r;
    assign tc  = (cnt_r == LAST);

    // Count register: clear has priority, wraps to zero after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (en) begin
            if (tc) begin
                cnt_r <= ZERO;
            end else begin
                cnt_r <= cnt_r + ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back frames.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);

    piso_state_t      state_r, state_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic             done_r, done_s;
    logic [CW-1:0]    cnt_s;
    logic             tc_s;
    logic             consume_s;
    logic             last_s;
    logic             ready_s;
    logic             accept_s;
    logic             sout_s;

    // A bit is consumed on any enabled edge while a frame is in flight.
    assign consume_s = (state_r == SHIFT) && shift_en;
    assign last_s    = consume_s && tc_s;
    // Ready in IDLE, or exactly when the final bit leaves so the next frame follows with no gap.
    assign ready_s   = (state_r == IDLE) || last_s;
    assign accept_s  = load_valid && ready_s;

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept_s),
        .en  (consume_s),
        .cnt (cnt_s),
        .tc  (tc_s)
    );

    // Next-state, shift-register and done decode; a new load always wins over draining.
    always_comb begin
        state_s = state_r;
        sreg_s  = sreg_r;
        done_s  = last_s;
        if (accept_s) begin
            state_s = SHIFT;
            sreg_s  = load_data;
        end else if (consume_s) begin
            if (tc_s) begin
                state_s = IDLE;
                sreg_s  = {WIDTH{1'b0}};
            end else if (MSB_FIRST) begin
                sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
            end else begin
                sreg_s = {1'b0, sreg_r[WIDTH-1:1]};
            end
        end else begin
            state_s = state_r;
            sreg_s  = sreg_r;
        end
    end

    // State, shift register and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sreg_r  <= sreg_s;
            done_r  <= done_s;
        end
    end

    // Serial data comes from the output end of the shift register; quiet when idle.
    always_comb begin
        sout_s = 1'b0;
        case (state_r)
            SHIFT:   sout_s = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];
            IDLE:    sout_s = 1'b0;
            default: sout_s = 1'b0;
        endcase
    end

    assign load_ready = ready_s;
    assign sout       = sout_s;
    assign sout_valid = (state_r == SHIFT);
    assign sout_first = (state_r == SHIFT) && (cnt_s == {CW{1'b0}});
    assign done       = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances share stimulus.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         shift_en = 1'b0;

    logic load_ready, sout, sout_valid, sout_first, done;
    logic load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the frame word plus the index of the bit on the line.
    logic         m_active;
    logic [W-1:0] m_word;
    int           m_k;
    logic         m_done;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .shift_en(shift_en), .sout(sout),
        .sout_valid(sout_valid), .sout_first(sout_first), .done(done)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_l), .shift_en(shift_en), .sout(sout_l),
        .sout_valid(sout_valid_l), .sout_first(sout_first_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 1'b0;
        m_word   = '0;
        m_k      = 0;
        m_done   = 1'b0;
    endtask

    // Expected {load_ready, sout, sout_valid, sout_first, done} for the current cycle.
    function automatic logic [4:0] exp_vec(input logic msb);
        logic s;
        logic r;
        s = 1'b0;
        if (m_active) s = msb ? m_word[W-1-m_k] : m_word[m_k];
        r = !m_active || (m_k == W-1 && shift_en);
        return {r, s, m_active, m_active && (m_k == 0), m_done};
    endfunction

    // Advance one clock edge and update the model from the inputs seen on that edge.
    task automatic tick();
        logic ready, acc, last;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ready  = !m_active || (m_k == W-1 && shift_en);
            acc    = load_valid && ready;
            last   = m_active && shift_en && (m_k == W-1);
            m_done = last;
            if (acc) begin
                m_active = 1'b1;
                m_word   = load_data;
                m_k      = 0;
            end else if (m_active && shift_en) begin
                if (last) m_active = 1'b0;
                else      m_k = m_k + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== 5'b10000 ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got %b/%b want 10000",
                    i, {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l});
            end
        end
        #2 rst = 1'b0;
        load_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] pat;
        pat = 8'hA5;
        load_valid = 1'b1; load_data = pat; shift_en = 1'b1;
        #1;
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready got %b want 1", load_ready);
        end
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            #1;
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== exp_vec(1'b1) ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== exp_vec(1'b0)) begin
                n_fail++;
                $display("FAIL single_model k=%0d got %b/%b want %b/%b", k,
                    {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l},
                    exp_vec(1'b1), exp_vec(1'b0));
            end
            if (k < W) begin
                n_checks++;
                if (sout !== pat[W-1-k] || sout_first !== (k == 0) || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_bit k=%0d got sout=%b first=%b done=%b want %b %b 0",
                        k, sout, sout_first, done, pat[W-1-k], (k == 0));
                end
            end else if (k == W) begin
                n_checks++;
                if (done !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_done got done=%b valid=%b sout=%b want 1 0 0",
                        done, sout_valid, sout);
                end
            end else begin
                n_checks++;
                if (done !== 1'b0 || load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_idle got done=%b ready=%b want 0 1", done, load_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        #1;
        tick();
        load_data = 8'h3C;
        for (int c = 1; c <= 2 * W + 2; c++) begin
            #1;
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== exp_vec(1'b1) ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== exp_vec(1'b0)) begin
                n_fail++;
                $display("FAIL b2b_model c=%0d got %b/%b want %b/%b", c,
                    {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l},
                    exp_vec(1'b1), exp_vec(1'b0));
            end
            if (c <= W) begin
                n_checks++;
                if (load_ready !== (c == W)) begin
                    n_fail++; $display("FAIL b2b_ready c=%0d got %b want %b", c, load_ready, (c == W));
                end
            end
            if (c == W + 1 || c == 2 * W + 1) begin
                n_checks++;
                if (done !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_done c=%0d got %b want 1", c, done);
                end
            end
            if (c == W + 1) begin
                n_checks++;
                if (sout_first !== 1'b1 || sout !== 1'b0 || sout_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_first got first=%b sout=%b valid=%b want 1 0 1",
                        sout_first, sout, sout_valid);
                end
            end
            tick();
            if (c == W) load_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int n_en;
        pat = 4'b1001;
        n_en = 0;
        load_valid = 1'b1; load_data = 8'hF0; shift_en = 1'b1;
        #1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 40 && sout_valid; c++) begin
            shift_en = pat[3 - (c % 4)];
            #1;
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== exp_vec(1'b1) ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== exp_vec(1'b0)) begin
                n_fail++;
                $display("FAIL stall_model c=%0d got %b/%b want %b/%b", c,
                    {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l},
                    exp_vec(1'b1), exp_vec(1'b0));
            end
            if (shift_en) n_en++;
            tick();
        end
        n_checks++;
        if (sout_valid !== 1'b0 || done !== 1'b1 || n_en != W) begin
            n_fail++;
            $display("FAIL stall_end got valid=%b done=%b enabled_edges=%0d want 0 1 %0d",
                sout_valid, done, n_en, W);
        end
        shift_en = 1'b1;
        tick();
    endtask

    task automatic test_lsb();
        logic [W-1:0] pat;
        pat = 8'h01;
        load_valid = 1'b1; load_data = pat; shift_en = 1'b1;
        #1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            #1;
            n_checks++;
            if (sout_l !== pat[k] || sout !== pat[W-1-k] || sout_first_l !== (k == 0)) begin
                n_fail++;
                $display("FAIL lsb_bit k=%0d got lsb=%b msb=%b first=%b want %b %b %b",
                    k, sout_l, sout, sout_first_l, pat[k], pat[W-1-k], (k == 0));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_abort();
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        #1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #2 rst = 1'b1;
        load_valid = 1'b1; load_data = 8'hFF;
        #1;
        n_checks++;
        if ({load_ready, sout, sout_valid, sout_first, done} !== 5'b10000 ||
            {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== 5'b10000) begin
            n_fail++;
            $display("FAIL abort_async got %b/%b want 10000",
                {load_ready, sout, sout_valid, sout_first, done},
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l});
        end
        tick();
        #2 rst = 1'b0;
        load_valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || sout_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_nodone got done=%b valid=%b want 0 0", done, sout_valid);
        end
        tick();
        load_valid = 1'b1; load_data = 8'h5A;
        #1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < W + 1; k++) begin
            #1;
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== exp_vec(1'b1) ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== exp_vec(1'b0)) begin
                n_fail++;
                $display("FAIL abort_restart k=%0d got %b/%b want %b/%b", k,
                    {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l},
                    exp_vec(1'b1), exp_vec(1'b0));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic acc;
        load_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!load_valid && $urandom_range(0, 2) != 0) begin
                load_valid = 1'b1;
                load_data  = W'($urandom);
            end
            shift_en = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if ({load_ready, sout, sout_valid, sout_first, done} !== exp_vec(1'b1) ||
                {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l} !== exp_vec(1'b0)) begin
                n_fail++;
                $display("FAIL random c=%0d got %b/%b want %b/%b", c,
                    {load_ready, sout, sout_valid, sout_first, done},
                    {load_ready_l, sout_l, sout_valid_l, sout_first_l, done_l},
                    exp_vec(1'b1), exp_vec(1'b0));
            end
            acc = load_valid && exp_vec(1'b1) >> 4;
            tick();
            if (acc) load_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_lsb();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
